axi_ram_responder: RTL and testbench

AXI4 full-protocol slave endpoint backed by an internal byte-addressable RAM; the responder that terminates one `m_axi_*` port of the AXI interconnect. Independent write and read state machines accept one burst each at a time and support FIXED, INCR and WRAP bursts with byte strobes. It serves as a simulation memory target in cocotb benches and as a small on-chip scratch RAM in the SoC.

---
 rtl/axi_pkg.sv | 28 ++
 rtl/axi_burst_addr.sv | 30 +++
 rtl/axi_ram_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_ram_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encodings, response codes, FSM state types
// and the burst legality check used by both the write and read channels.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // max_size is log2 of the bus width in bytes
    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size,
                                       input logic [7:0] len, input logic [2:0] max_size);
        return (burst == 2'b11) || (size > max_size) ||
               ((burst == WRAP) && !wrap_len_ok(len));
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] incr_addr;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        // window is (len+1) beats of 2**size bytes, aligned to its own size
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        incr_addr = addr + step;
        case (burst)
            INCR:    next_addr = incr_addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave backed by a byte-addressable RAM; independent write and read
// burst engines, each handling one burst at a time.
module axi_ram_responder
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awregion,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wuser,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arregion,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int WORDS  = 2 ** (ADDR_WIDTH - LSB);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic unused_ok;
    assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awregion,
                         s_axi_awqos, s_axi_awuser, s_axi_wuser, s_axi_arlock,
                         s_axi_arcache, s_axi_arprot, s_axi_arregion, s_axi_arqos,
                         s_axi_aruser};
    assign s_axi_buser = 1'b0;
    assign s_axi_ruser = 1'b0;

    // ---------------- write channel ----------------
    w_state_t              w_state, w_next;
    logic [ADDR_WIDTH-1:0] w_addr, w_addr_next;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_err, w_wlast_err;
    logic                  aw_fire, w_fire, b_fire, w_last_beat;

    assign aw_fire     = s_axi_awvalid & s_axi_awready;
    assign w_fire      = s_axi_wvalid & s_axi_wready;
    assign b_fire      = s_axi_bvalid & s_axi_bready;
    assign w_last_beat = (w_cnt == w_len);

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_addr (
        .addr      (w_addr),
        .size      (w_size),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (w_addr_next)
    );

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_next = W_DATA;
            W_DATA:  if (w_fire && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_fire) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they stay low
    // through reset and rise on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= OKAY;
        end else begin
            w_state       <= w_next;
            s_axi_awready <= (w_next == W_IDLE);
            s_axi_wready  <= (w_next == W_DATA);
            s_axi_bvalid  <= (w_next == W_RESP);
            if (aw_fire)
                s_axi_bid <= s_axi_awid;
            if (w_fire && w_last_beat)
                s_axi_bresp <= (w_err || w_wlast_err || !s_axi_wlast) ? SLVERR : OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_fire) begin
            w_addr      <= s_axi_awaddr;
            w_len       <= s_axi_awlen;
            w_size      <= s_axi_awsize;
            w_burst     <= s_axi_awburst;
            w_cnt       <= '0;
            w_err       <= burst_err(s_axi_awburst, s_axi_awsize, s_axi_awlen, 3'(LSB));
            w_wlast_err <= 1'b0;
        end else if (w_fire) begin
            w_addr <= w_addr_next;
            w_cnt  <= w_cnt + 8'd1;
            if (s_axi_wlast != w_last_beat)
                w_wlast_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire && !w_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b])
                    mem[w_addr[ADDR_WIDTH-1:LSB]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_next, rd_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_err, rd_err;
    logic                  ar_fire, r_fire, r_load;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ar_fire = s_axi_arvalid & s_axi_arready;
    assign r_fire  = s_axi_rvalid & s_axi_rready;
    assign r_load  = ar_fire | (r_fire & ~s_axi_rlast);

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_addr (
        .addr      (r_addr),
        .size      (r_size),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_addr_next)
    );

    // The beat being loaded comes from the AR address on the first beat,
    // otherwise from the address following the beat just accepted.
    assign rd_addr = ar_fire ? s_axi_araddr : r_addr_next;
    assign rd_err  = ar_fire ? burst_err(s_axi_arburst, s_axi_arsize, s_axi_arlen, 3'(LSB))
                             : r_err;
    assign rd_word = mem[rd_addr[ADDR_WIDTH-1:LSB]];

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_next = R_DATA;
            R_DATA:  if (r_fire && s_axi_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= OKAY;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
        end else begin
            r_state       <= r_next;
            s_axi_arready <= (r_next == R_IDLE);
            s_axi_rvalid  <= (r_next == R_DATA);
            if (ar_fire)
                s_axi_rid <= s_axi_arid;
            if (r_load) begin
                s_axi_rdata <= rd_err ? '0 : rd_word;
                s_axi_rresp <= rd_err ? SLVERR : OKAY;
                s_axi_rlast <= ar_fire ? (s_axi_arlen == 8'd0) : ((r_cnt + 8'd1) == r_len);
            end else if (r_fire) begin
                s_axi_rlast <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ar_fire) begin
            r_addr  <= s_axi_araddr;
            r_len   <= s_axi_arlen;
            r_size  <= s_axi_arsize;
            r_burst <= s_axi_arburst;
            r_cnt   <= '0;
            r_err   <= rd_err;
        end else if (r_fire && !s_axi_rlast) begin
            r_addr <= r_addr_next;
            r_cnt  <= r_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed bench for axi_ram_responder with a byte-level reference memory
// and scoreboard queues for B responses and R beats.
module tb_axi_ram_responder;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_axi_awid = '0;
    logic [15:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = '0;
    logic [1:0]  s_axi_awburst = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_buser;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [3:0]  s_axi_arid = '0;
    logic [15:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = '0;
    logic [1:0]  s_axi_arburst = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_ruser;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    always #5 clk = ~clk;

    axi_ram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
        .s_axi_awregion(4'd0), .s_axi_awqos(4'd0), .s_axi_awuser(1'b0),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wuser(1'b0), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arregion(4'd0), .s_axi_arqos(4'd0), .s_axi_aruser(1'b0),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] ref_mem [0:65535];

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t rq[$];
    bexp_t  bq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] tb_next(input logic [15:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
        int unsigned step, total, lower, n;
        step = 1 << size;
        n = a + step;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            total = (len + 1) * step;
            lower = (a / total) * total;
            if (n >= lower + total) n = lower;
        end
        return n[15:0];
    endfunction

    function automatic logic tb_err(input logic [1:0] burst, input logic [2:0] size,
                                    input logic [7:0] len);
        return (burst == 2'b11) || (size > 3'd2) ||
               (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        int w;
        w = a & 16'hFFFC;
        return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [31:0] base, input logic [31:0] inc,
                             input logic [3:0] strb, input int wlast_at, input int bready_delay);
        logic        err;
        logic [15:0] a;
        logic [31:0] d;
        int          n;
        bexp_t       e;
        err = tb_err(burst, size, len);
        a   = addr;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
        check("aw_accept", n < 50, 1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        check("w_latency", s_axi_wready, 1);
        for (int i = 0; i <= len; i++) begin
            d = base + i * inc;
            s_axi_wdata = d; s_axi_wstrb = strb; s_axi_wlast = (i == wlast_at);
            s_axi_wvalid = 1'b1;
            n = 0;
            while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
            check("w_accept", n < 50, 1);
            if (!err)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[(a & 16'hFFFC) + b] = d[b*8 +: 8];
            @(negedge clk);
            a = tb_next(a, size, len, burst);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        e.id   = id;
        e.resp = (err || wlast_at != int'(len)) ? 2'b10 : 2'b00;
        bq.push_back(e);
        check("b_latency", s_axi_bvalid, 1);
        for (int k = 0; k < bready_delay; k++) begin
            @(negedge clk);
            check("b_hold_valid", s_axi_bvalid, 1);
            check("b_hold_id", s_axi_bid, id);
        end
        s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
        check("b_arrive", n < 50, 1);
        e = bq.pop_front();
        check("bid", s_axi_bid, e.id);
        check("bresp", s_axi_bresp, e.resp);
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("b_drop", s_axi_bvalid, 0);
        check("aw_after_b", s_axi_awready, 1);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int toggle, input int abort_at);
        logic        err, held, hl;
        logic [15:0] a;
        logic [31:0] hd;
        int          n, got, cyc;
        rbeat_t      e;
        err = tb_err(burst, size, len);
        a   = addr;
        for (int i = 0; i <= len; i++) begin
            e.data = err ? 32'd0 : ref_word(a);
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            e.id   = id;
            rq.push_back(e);
            a = tb_next(a, size, len, burst);
        end
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
        check("ar_accept", n < 50, 1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check("r_latency", s_axi_rvalid, 1);
        got = 0; cyc = 0; held = 1'b0; hd = '0; hl = 1'b0;
        while (got <= int'(len) && cyc < 200) begin
            if (got == abort_at) begin
                s_axi_rready = 1'b0;
                return;
            end
            s_axi_rready = (toggle == 0) ? 1'b1 : (cyc % 2 == 0);
            if (s_axi_rvalid) begin
                if (held) begin
                    check("r_stable_data", s_axi_rdata, hd);
                    check("r_stable_last", s_axi_rlast, hl);
                end
                if (s_axi_rready) begin
                    e = rq.pop_front();
                    check("rdata", s_axi_rdata, e.data);
                    check("rresp", s_axi_rresp, e.resp);
                    check("rlast", s_axi_rlast, e.last);
                    check("rid", s_axi_rid, e.id);
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; hd = s_axi_rdata; hl = s_axi_rlast;
                end
            end
            @(negedge clk);
            cyc++;
        end
        s_axi_rready = 1'b0;
        check("r_beats", got, int'(len) + 1);
        check("r_drop", s_axi_rvalid, 0);
        check("ar_after_r", s_axi_arready, 1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_awready", s_axi_awready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_arready", s_axi_arready, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rlast", s_axi_rlast, 0);
        check("rst_bresp_bid", {s_axi_bresp, s_axi_bid}, 0);
        check("rst_rresp_rid", {s_axi_rresp, s_axi_rid}, 0);
        check("rst_rdata", s_axi_rdata, 0);
        rst = 1'b0;
        #1;
        check("awready_at_release", s_axi_awready, 0);
        @(negedge clk);
        check("awready_after_release", s_axi_awready, 1);
        check("arready_after_release", s_axi_arready, 1);

        // INCR burst written and read back, then a WRAP read over it
        axi_write(4'd5, 16'h0100, 8'd3, 3'd2, INCR, 32'h11111111, 32'h11111111, 4'hF, 3, 0);
        axi_read(4'd5, 16'h0100, 8'd3, 3'd2, INCR, 0, -1);
        axi_read(4'd3, 16'h010C, 8'd3, 3'd2, WRAP, 0, -1);

        // partial strobe onto a zeroed word
        axi_write(4'd1, 16'h0020, 8'd0, 3'd2, INCR, 32'h00000000, 32'd0, 4'hF, 0, 0);
        axi_write(4'd1, 16'h0020, 8'd0, 3'd2, INCR, 32'hAABBCCDD, 32'd0, 4'b0101, 0, 0);
        check("partial_ref", ref_word(16'h0020), 32'h00BB00DD);
        axi_read(4'd1, 16'h0020, 8'd0, 3'd2, INCR, 0, -1);

        // backpressure on R and B
        axi_read(4'd7, 16'h0100, 8'd3, 3'd2, INCR, 1, -1);
        axi_write(4'd9, 16'h0200, 8'd0, 3'd2, INCR, 32'hCAFEF00D, 32'd0, 4'hF, 0, 5);
        axi_read(4'd9, 16'h0200, 8'd0, 3'd2, INCR, 0, -1);

        // illegal burst type leaves memory untouched
        axi_write(4'd2, 16'h0100, 8'd1, 3'd2, 2'b11, 32'hDEADBEEF, 32'd1, 4'hF, 1, 0);
        axi_read(4'd2, 16'h0100, 8'd1, 3'd2, INCR, 0, -1);

        // early wlast: data still lands, response is an error
        axi_write(4'd4, 16'h0300, 8'd3, 3'd2, INCR, 32'h01020304, 32'h10101010, 4'hF, 1, 0);
        axi_read(4'd4, 16'h0300, 8'd3, 3'd2, INCR, 0, -1);

        // oversize read beats
        axi_read(4'd6, 16'h0100, 8'd2, 3'd3, INCR, 0, -1);

        // FIXED write: second beat overwrites the same word
        axi_write(4'd8, 16'h0500, 8'd1, 3'd2, FIXED, 32'h12345678, 32'h11111111, 4'hF, 1, 0);
        axi_read(4'd8, 16'h0500, 8'd0, 3'd2, INCR, 0, -1);

        // reset in the middle of a read burst
        axi_write(4'd3, 16'h0400, 8'd7, 3'd2, INCR, 32'hA0000000, 32'd1, 4'hF, 7, 0);
        axi_read(4'd3, 16'h0400, 8'd7, 3'd2, INCR, 0, 2);
        rst = 1'b1;
        #1;
        check("midrst_rvalid", s_axi_rvalid, 0);
        check("midrst_arready", s_axi_arready, 0);
        check("midrst_awready", s_axi_awready, 0);
        rq.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_arready_release", s_axi_arready, 0);
        @(negedge clk);
        check("midrst_arready_back", s_axi_arready, 1);
        axi_read(4'd3, 16'h0400, 8'd7, 3'd2, INCR, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
